// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, drives the ROM address and presents
// the fetched instruction to decode, with a one-entry hold buffer that covers stalls.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] irom_addr,
  input  logic [31:0] irom_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_if,
  output logic [31:0] pc_dec,
  output logic [31:0] inst_dec,
  output logic        valid_dec
);

  logic [31:0] hold_inst;
  logic        hold_vld;
  logic        redirect_lsb_unused;

  // Targets are word aligned; the low two bits are discarded by design.
  assign redirect_lsb_unused = ^redirect_pc[1:0];

  assign irom_addr = pc_if;

  // IF -> ID boundary: redirect beats stall, stall beats advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_if     <= RESET_PC;
      pc_dec    <= 32'h0000_0000;
      valid_dec <= 1'b0;
      hold_inst <= 32'h0000_0000;
      hold_vld  <= 1'b0;
    end else if (redirect_valid) begin
      pc_if     <= {redirect_pc[31:2], 2'b00};
      valid_dec <= 1'b0;
      hold_vld  <= 1'b0;
    end else if (stall) begin
      // The ROM re-reads pc_if while stalled, so keep the decoder's word here.
      if (!hold_vld) begin
        hold_inst <= irom_rdata;
        hold_vld  <= 1'b1;
      end
    end else begin
      pc_dec    <= pc_if;
      pc_if     <= pc_if + 32'd4;
      valid_dec <= 1'b1;
      hold_vld  <= 1'b0;
    end
  end

  always_comb begin
    inst_dec = irom_rdata;
    if (!valid_dec)
      inst_dec = NOP_INST;
    else if (hold_vld)
      inst_dec = hold_inst;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: straight-line fetch, stalls, redirects, wrap-around
// and asynchronous reset, against a registered-read ROM with mem[i] = 32'h1000_0000 + i.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] irom_addr, irom_rdata, pc_if, pc_dec, inst_dec;
  logic        valid_dec;

  logic [31:0] irom_addr_w, irom_rdata_w, pc_if_w, pc_dec_w, inst_dec_w;
  logic        valid_dec_w;
  logic        stall_w, redirect_valid_w;
  logic [31:0] redirect_pc_w;

  int n_checks;
  int n_fail;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .irom_addr     (irom_addr),
    .irom_rdata    (irom_rdata),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .pc_if         (pc_if),
    .pc_dec        (pc_dec),
    .inst_dec      (inst_dec),
    .valid_dec     (valid_dec)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk           (clk),
    .rst           (rst),
    .irom_addr     (irom_addr_w),
    .irom_rdata    (irom_rdata_w),
    .stall         (stall_w),
    .redirect_valid(redirect_valid_w),
    .redirect_pc   (redirect_pc_w),
    .pc_if         (pc_if_w),
    .pc_dec        (pc_dec_w),
    .inst_dec      (inst_dec_w),
    .valid_dec     (valid_dec_w)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    return 32'h1000_0000 + (addr >> 2);
  endfunction

  always_ff @(posedge clk) begin
    irom_rdata   <= rom_word(irom_addr);
    irom_rdata_w <= rom_word(irom_addr_w);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_dec(input string tag, input logic [31:0] e_pc_if,
                           input logic [31:0] e_pc_dec, input logic [31:0] e_inst,
                           input logic e_vld);
    check({tag, ".pc_if"}, pc_if, e_pc_if);
    check({tag, ".irom_addr"}, irom_addr, e_pc_if);
    check({tag, ".pc_dec"}, pc_dec, e_pc_dec);
    check({tag, ".inst_dec"}, inst_dec, e_inst);
    check({tag, ".valid_dec"}, {31'd0, valid_dec}, {31'd0, e_vld});
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    stall_w = 1'b0;
    redirect_valid_w = 1'b0;
    redirect_pc_w = 32'h0;

    tick();
    tick();
    check_dec("reset", 32'h0, 32'h0, 32'h0000_0013, 1'b0);
    check("reset.wrap_pc_if", pc_if_w, 32'hFFFF_FFF8);
    rst = 1'b0;

    // Straight-line fetch up to pc_dec=8; wrap instance runs alongside.
    tick();
    check_dec("line0", 32'h4, 32'h0, 32'h1000_0000, 1'b1);
    check("wrap.edge1", pc_if_w, 32'hFFFF_FFFC);
    tick();
    check_dec("line1", 32'h8, 32'h4, 32'h1000_0001, 1'b1);
    check("wrap.edge2", pc_if_w, 32'h0000_0000);
    check("wrap.pc_dec", pc_dec_w, 32'hFFFF_FFFC);
    check("wrap.inst", inst_dec_w, 32'h4FFF_FFFF);
    tick();
    check_dec("line2", 32'hC, 32'h8, 32'h1000_0002, 1'b1);

    // Three-cycle stall holds pc_dec=8.
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_dec($sformatf("stall%0d", k), 32'hC, 32'h8, 32'h1000_0002, 1'b1);
    end
    stall = 1'b0;
    tick();
    check_dec("release", 32'h10, 32'hC, 32'h1000_0003, 1'b1);
    tick();
    check_dec("line4", 32'h14, 32'h10, 32'h1000_0004, 1'b1);
    tick();
    check_dec("line5", 32'h18, 32'h14, 32'h1000_0005, 1'b1);

    // Redirect with misaligned target: one bubble then the target.
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0043;
    tick();
    check_dec("redir.bubble", 32'h40, 32'h14, 32'h0000_0013, 1'b0);
    redirect_valid = 1'b0;
    tick();
    check_dec("redir.target", 32'h44, 32'h40, 32'h1000_0010, 1'b1);

    // Stall and redirect together: redirect wins.
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0020;
    tick();
    check_dec("both.bubble", 32'h20, 32'h40, 32'h0000_0013, 1'b0);
    stall = 1'b0;
    redirect_valid = 1'b0;
    tick();
    check_dec("both.target", 32'h24, 32'h20, 32'h1000_0008, 1'b1);

    // Redirect in the middle of a multi-cycle stall.
    stall = 1'b1;
    tick();
    check_dec("mstall.hold", 32'h24, 32'h20, 32'h1000_0008, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    tick();
    check_dec("mstall.redir", 32'h100, 32'h20, 32'h0000_0013, 1'b0);
    redirect_valid = 1'b0;
    tick();
    check_dec("mstall.bub1", 32'h100, 32'h20, 32'h0000_0013, 1'b0);
    tick();
    check_dec("mstall.bub2", 32'h100, 32'h20, 32'h0000_0013, 1'b0);
    stall = 1'b0;
    tick();
    check_dec("mstall.rel", 32'h104, 32'h100, 32'h1000_0040, 1'b1);

    // Asynchronous reset while the hold buffer is occupied.
    stall = 1'b1;
    tick();
    tick();
    check_dec("rstmid.hold", 32'h104, 32'h100, 32'h1000_0040, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    check_dec("rstmid.async", 32'h0, 32'h0, 32'h0000_0013, 1'b0);
    stall = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check_dec("rstmid.first", 32'h4, 32'h0, 32'h1000_0000, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
